// File: rtl/id_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : id_seq_pkg
//  Description : Shared types and constants for the ID digit sequencer:
//                run-state enum, blank pattern and 0..9 seven-segment glyphs.
//  Revision    : 1.0 - initial release
// ============================================================================
package id_seq_pkg;

    typedef enum logic [0:0] {
        PAUSED  = 1'b0,
        RUNNING = 1'b1
    } seq_state_e;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_TABLE [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] pattern;
        pattern = SEG_BLANK;
        for (int i = 0; i < 10; i++) begin
            if (digit == 4'(i)) begin
                pattern = SEG_TABLE[i];
            end
        end
        return pattern;
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_tick_timer.sv
`default_nettype none
// ============================================================================
//  Module      : id_tick_timer
//  Description : Free-running 0..TICK_COUNT-1 period counter with a one-cycle
//                tick at terminal count; restart holds/forces the count to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_tick_timer #(
    parameter int TICK_COUNT = 50000000
) (
    input  logic clk,
    input  logic Reset_n,
    input  logic restart,
    output logic tick
);

    localparam int              CNT_W      = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
    localparam logic [CNT_W-1:0] c_TERM_CNT = CNT_W'(TICK_COUNT - 1);

    logic [CNT_W-1:0] r_cnt_q;
    logic [CNT_W-1:0] w_cnt_d;

    always_comb begin
        w_cnt_d = r_cnt_q + CNT_W'(1);
        if (restart || (r_cnt_q == c_TERM_CNT)) begin
            w_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign tick = (r_cnt_q == c_TERM_CNT);

endmodule
`default_nettype wire

// File: rtl/id_digit_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : id_digit_sequencer
//  Description : Steps through packed BCD ID digits, automatically on a timer
//                tick while running or by a synchronised button while paused.
//                Define ID_SEQ_SEG7_EN to enable the seven-segment decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_digit_sequencer
    import id_seq_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int TICK_COUNT = 50000000,
    parameter int POS_W      = $clog2(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    Reset_n,
    input  logic [NUM_DIGITS*4-1:0] id_digits,
    input  logic                    run,
    input  logic                    dir,
    input  logic                    step,
    input  logic                    clear,
    output logic [3:0]              numeral,
    output logic [POS_W-1:0]        position,
    output logic                    wrap,
    output logic [6:0]              seg_n
);

    localparam logic [POS_W-1:0] c_POS_LAST = POS_W'(NUM_DIGITS - 1);

    seq_state_e       r_state_q;
    seq_state_e       w_state_d;
    logic [1:0]       r_sync_q;
    logic [1:0]       w_sync_d;
    logic             r_step_prev_q;
    logic             w_step_prev_d;
    logic [1:0]       r_warm_q;
    logic [1:0]       w_warm_d;
    logic [POS_W-1:0] r_pos_q;
    logic [POS_W-1:0] w_pos_d;
    logic             r_wrap_q;
    logic             w_wrap_d;

    logic             w_restart;
    logic             w_tick;
    logic             w_step_edge;
    logic             w_advance;

    // Timer is held at zero while paused, so entering RUNNING starts a full period
    assign w_restart = clear || (r_state_q == PAUSED);

    id_tick_timer #(
        .TICK_COUNT (TICK_COUNT)
    ) u_tick_timer (
        .clk     (clk),
        .Reset_n (Reset_n),
        .restart (w_restart),
        .tick    (w_tick)
    );

    // Edge detect only once the previous-sample flop holds a genuine post-reset
    // sample; a button held through reset must not look like a fresh press.
    assign w_step_edge = r_sync_q[1] && !r_step_prev_q && (r_warm_q == 2'd3);

    always_comb begin
        w_state_d     = run ? RUNNING : PAUSED;
        w_sync_d      = {r_sync_q[0], step};
        w_step_prev_d = r_sync_q[1];
        w_warm_d      = (r_warm_q == 2'd3) ? r_warm_q : (r_warm_q + 2'd1);
    end

    always_comb begin
        w_advance = (r_state_q == RUNNING) ? w_tick : w_step_edge;
        w_pos_d   = r_pos_q;
        w_wrap_d  = 1'b0;
        if (clear) begin
            w_pos_d = '0;
        end else if (w_advance) begin
            if (!dir) begin
                if (r_pos_q == c_POS_LAST) begin
                    w_pos_d  = '0;
                    w_wrap_d = 1'b1;
                end else begin
                    w_pos_d = r_pos_q + POS_W'(1);
                end
            end else begin
                if (r_pos_q == '0) begin
                    w_pos_d  = c_POS_LAST;
                    w_wrap_d = 1'b1;
                end else begin
                    w_pos_d = r_pos_q - POS_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state_q     <= PAUSED;
            r_sync_q      <= '0;
            r_step_prev_q <= 1'b0;
            r_warm_q      <= '0;
            r_pos_q       <= '0;
            r_wrap_q      <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_sync_q      <= w_sync_d;
            r_step_prev_q <= w_step_prev_d;
            r_warm_q      <= w_warm_d;
            r_pos_q       <= w_pos_d;
            r_wrap_q      <= w_wrap_d;
        end
    end

    assign position = r_pos_q;
    assign wrap     = r_wrap_q;
    assign numeral  = id_digits[{r_pos_q, 2'b00} +: 4];

`ifdef ID_SEQ_SEG7_EN
    assign seg_n = seg_decode(numeral);
`else
    assign seg_n = SEG_BLANK;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_digit_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_digit_sequencer
//  Description : Scoreboard bench: a cycle-level reference model pushes the
//                expected outputs, a negedge monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_digit_sequencer;

    localparam int NUM_DIGITS = 3;
    localparam int TICK_COUNT = 4;
    localparam int POS_W      = 2;

    logic                    clk       = 1'b0;
    logic                    Reset_n   = 1'b0;
    logic [NUM_DIGITS*4-1:0] id_digits = 12'h521;
    logic                    run       = 1'b0;
    logic                    dir       = 1'b0;
    logic                    step      = 1'b0;
    logic                    clear     = 1'b0;
    logic [3:0]              numeral;
    logic [POS_W-1:0]        position;
    logic                    wrap;
    logic [6:0]              seg_n;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_digit_sequencer #(
        .NUM_DIGITS (NUM_DIGITS),
        .TICK_COUNT (TICK_COUNT),
        .POS_W      (POS_W)
    ) dut (
        .clk       (clk),
        .Reset_n   (Reset_n),
        .id_digits (id_digits),
        .run       (run),
        .dir       (dir),
        .step      (step),
        .clear     (clear),
        .numeral   (numeral),
        .position  (position),
        .wrap      (wrap),
        .seg_n     (seg_n)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] exp_seg(input int d);
`ifdef ID_SEQ_SEG7_EN
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
`else
        return 7'h7F;
`endif
    endfunction

    function automatic int digit_at(input int p);
        return int'((id_digits >> (4 * p)) & 12'hF);
    endfunction

    // Reference model: behaviour after each clock edge, from inputs seen at it
    typedef struct {
        int pos;
        bit wrp;
    } exp_t;

    exp_t sb_q[$];
    int   m_pos  = 0;
    bit   m_wrap = 1'b0;
    bit   m_run  = 1'b0;
    int   m_age  = 0;
    int   m_k    = 0;
    bit   m_hist[$];

    always @(posedge clk) begin : model
        bit adv;
        bit edg;
        exp_t e;
        if (!Reset_n) begin
            m_pos  = 0;
            m_wrap = 1'b0;
            m_run  = 1'b0;
            m_age  = 0;
            m_k    = 0;
            m_hist.delete();
        end else begin
            m_k++;
            m_hist.push_back(step);
            if (m_hist.size() > 4) void'(m_hist.pop_front());
            // press seen two edges after sampling, needing a real low sample before it
            edg = (m_k >= 4) && m_hist[1] && !m_hist[0];
            adv = 1'b0;
            if (!clear) adv = m_run ? ((m_age % TICK_COUNT) == TICK_COUNT - 1) : edg;
            m_wrap = 1'b0;
            if (clear) begin
                m_pos = 0;
            end else if (adv) begin
                if (!dir) begin
                    m_wrap = (m_pos == NUM_DIGITS - 1);
                    m_pos  = (m_pos + 1) % NUM_DIGITS;
                end else begin
                    m_wrap = (m_pos == 0);
                    m_pos  = (m_pos + NUM_DIGITS - 1) % NUM_DIGITS;
                end
            end
            m_age = (!m_run || clear) ? 0 : m_age + 1;
            m_run = run;
        end
        e.pos = m_pos;
        e.wrp = m_wrap;
        sb_q.push_back(e);
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (!Reset_n) begin
                e.pos = 0;
                e.wrp = 1'b0;
            end
            check("sb_position", 32'(position), 32'(e.pos));
            check("sb_wrap", 32'(wrap), 32'(e.wrp));
            check("sb_numeral", 32'(numeral), 32'(digit_at(e.pos)));
            check("sb_seg_n", 32'(seg_n), 32'(exp_seg(digit_at(e.pos))));
        end
    end

    task automatic after(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int p, input bit w, input int num);
        check({tag, "_position"}, 32'(position), 32'(p));
        check({tag, "_wrap"}, 32'(wrap), 32'(w));
        check({tag, "_numeral"}, 32'(numeral), 32'(num));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stimulus
        after(3);
        chk("reset", 0, 0, 1);
        Reset_n = 1'b1;
        after(1);
        run = 1'b1;
        // ascending auto-advance, four cycles per step
        after(4);  chk("asc_e3", 0, 0, 1);
        after(1);  chk("asc_e4", 1, 0, 2);
        after(4);  chk("asc_e8", 2, 0, 5);
        after(3);  chk("asc_e11", 2, 0, 5);
        after(1);  chk("asc_e12", 0, 1, 1);
        check("seg_glyph1", 32'(seg_n), 32'(exp_seg(1)));
        after(1);  chk("asc_e13", 0, 0, 1);
        // descending
        dir = 1'b1;
        after(3);  chk("desc_e16", 2, 1, 5);
        after(4);  chk("desc_e20", 1, 0, 2);
        after(4);  chk("desc_e24", 0, 0, 1);
        // clear collides with tick at position 2
        after(4);  chk("desc_e28", 2, 1, 5);
        after(3);  clear = 1'b1;
        after(1);  chk("clear_tick", 0, 0, 1);
        clear = 1'b0;
        after(3);  chk("clear_e35", 0, 0, 1);
        after(1);  chk("clear_e36", 2, 1, 5);
        // paused, manual steps
        run   = 1'b0;
        dir   = 1'b0;
        clear = 1'b1;
        after(1);
        clear = 1'b0;
        after(20); chk("pause_idle", 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step = 1'b1;
            after(2); chk("step_wait", i, 0, digit_at(i));
            after(1); chk("step_adv", (i + 1) % 3, i == 2, digit_at((i + 1) % 3));
            after(2); step = 1'b0;
            after(5);
        end
        // step held through reset
        step    = 1'b1;
        Reset_n = 1'b0;
        after(2);
        Reset_n = 1'b1;
        after(10); chk("step_thru_reset", 0, 0, 1);
        step = 1'b0;
        after(4);  chk("step_release", 0, 0, 1);
        step = 1'b1;
        after(3);  chk("step_repress", 1, 0, 2);
        step = 1'b0;
        after(3);
        // reset mid-period discards partial count
        run = 1'b1;
        after(2);
        Reset_n = 1'b0;
        after(2);
        Reset_n = 1'b1;
        after(4);  chk("rst_mid_e3", 0, 0, 1);
        after(1);  chk("rst_mid_e4", 1, 0, 2);
        // randomised traffic against the model
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(39) == 0) run = ~run;
            if ($urandom_range(29) == 0) dir = ~dir;
            if ($urandom_range(5) == 0) step = ~step;
            clear = ($urandom_range(49) == 0);
            if ($urandom_range(99) == 0) id_digits = 12'($urandom);
            if ($urandom_range(299) == 0) begin
                Reset_n = 1'b0;
                after(2);
                Reset_n = 1'b1;
            end
            after(1);
        end
        after(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
